muller_c_sched: RTL and testbench

//  Synchronous scheduler that shares one Muller C-element instance between NREQ requesters.

---
 rtl/muller_c_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_muller_c_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muller_c_sched.sv
// rtl/muller_c_sched.sv - round-robin scheduler sharing one Muller C-element; optional stats via MULLER_C_SCHED_STATS_EN
module muller_c_sched #(
    parameter int NREQ     = 4,
    parameter int TIMEOUT  = 16,
    parameter int HOLD_CYC = 4,
    parameter int CW       = 8,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_a,
    input  logic [NREQ-1:0] req_b,
    output logic [NREQ-1:0] req_ready,
    output logic            ce_a,
    output logic            ce_b,
    input  logic            ce_c,
    output logic            busy,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic            rsp_c,
    output logic            rsp_err,
    output logic [CW-1:0]   rsp_cycles
`ifdef MULLER_C_SCHED_STATS_EN
    ,
    output logic [15:0]     stat_txn,
    output logic [15:0]     stat_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    state_t          state_q, state_d;
    logic            c_meta_q, c_sync_q;
    logic            c_s;
    logic            a_q, b_q;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  last_grant_q;
    logic            c_prev_q;
    logic [CW-1:0]   cnt_q;
    logic            ce_a_q, ce_b_q;
    logic [IDW-1:0]  rsp_id_q;
    logic            rsp_c_q, rsp_err_q;
    logic [CW-1:0]   rsp_cycles_q;

    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic            wait_done, wait_err;
    int              scan_j;
    logic [IDW-1:0]  scan_idx;

    // The C-element output is asynchronous; only the twice-registered copy is ever used.
    assign c_s = c_sync_q;

    // Round-robin arbiter: first valid requester after the last one granted, wrapping.
    always_comb begin
        scan_j    = 0;
        scan_idx  = '0;
        grant_any = 1'b0;
        grant_idx = last_grant_q;
        for (int i = 1; i <= NREQ; i++) begin
            scan_j = int'(last_grant_q) + i;
            if (scan_j >= NREQ) begin
                scan_j = scan_j - NREQ;
            end
            scan_idx = IDW'(scan_j);
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in WAIT, follow/glitch detection outranks the cycle limit.
    always_comb begin
        state_d   = state_q;
        wait_done = 1'b0;
        wait_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (a_q == b_q) begin
                    if (c_s == a_q) begin
                        wait_done = 1'b1;
                    end else if (cnt_q == TO_LAST) begin
                        wait_done = 1'b1;
                        wait_err  = 1'b1;
                    end
                end else begin
                    if (c_s != c_prev_q) begin
                        wait_done = 1'b1;
                        wait_err  = 1'b1;
                    end else if (cnt_q == HOLD_LAST) begin
                        wait_done = 1'b1;
                    end
                end
                if (wait_done) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control outputs; the accept pulse is suppressed while reset is asserted.
    always_comb begin
        req_ready = '0;
        if ((state_q == S_IDLE) && grant_any && !wb_rst_i) begin
            req_ready[grant_idx] = 1'b1;
        end
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_RESP);
    end

    // Synchronizer, request latch, C-element drive, WAIT counter and response registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            c_meta_q     <= 1'b0;
            c_sync_q     <= 1'b0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            id_q         <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            c_prev_q     <= 1'b0;
            cnt_q        <= '0;
            ce_a_q       <= 1'b0;
            ce_b_q       <= 1'b0;
            rsp_id_q     <= '0;
            rsp_c_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_cycles_q <= '0;
        end else begin
            c_meta_q <= ce_c;
            c_sync_q <= c_meta_q;
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        a_q          <= req_a[grant_idx];
                        b_q          <= req_b[grant_idx];
                        id_q         <= grant_idx;
                        last_grant_q <= grant_idx;
                    end
                end
                S_DRIVE: begin
                    ce_a_q   <= a_q;
                    ce_b_q   <= b_q;
                    c_prev_q <= c_s;
                    cnt_q    <= '0;
                end
                S_WAIT: begin
                    if (wait_done) begin
                        rsp_id_q     <= id_q;
                        rsp_c_q      <= c_s;
                        rsp_err_q    <= wait_err;
                        rsp_cycles_q <= cnt_q;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ce_a       = ce_a_q;
    assign ce_b       = ce_b_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_cycles = rsp_cycles_q;

`ifdef MULLER_C_SCHED_STATS_EN
    logic [15:0] stat_txn_q, stat_err_q;

    // Saturating transaction and error counters, stepped on each response pulse.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stat_txn_q <= '0;
            stat_err_q <= '0;
        end else if (state_q == S_RESP) begin
            if (stat_txn_q != 16'hFFFF) begin
                stat_txn_q <= stat_txn_q + 16'd1;
            end
            if (rsp_err_q && (stat_err_q != 16'hFFFF)) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end

    assign stat_txn = stat_txn_q;
    assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_muller_c_sched.sv
// tb/tb_muller_c_sched.sv - directed self-checking bench for muller_c_sched
module tb_muller_c_sched;

    localparam int NREQ = 4;
    localparam int CW   = 8;

    logic            wb_clk_i  = 1'b0;
    logic            wb_rst_i  = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_a     = '0;
    logic [NREQ-1:0] req_b     = '0;
    logic [NREQ-1:0] req_ready;
    logic            ce_a, ce_b;
    logic            ce_c      = 1'b0;
    logic            busy, rsp_valid, rsp_c, rsp_err;
    logic [1:0]      rsp_id;
    logic [CW-1:0]   rsp_cycles;
`ifdef MULLER_C_SCHED_STATS_EN
    logic [15:0]     stat_txn, stat_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    muller_c_sched #(
        .NREQ(4), .TIMEOUT(16), .HOLD_CYC(4), .CW(8)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .ce_a       (ce_a),
        .ce_b       (ce_b),
        .ce_c       (ce_c),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_c      (rsp_c),
        .rsp_err    (rsp_err),
        .rsp_cycles (rsp_cycles)
`ifdef MULLER_C_SCHED_STATS_EN
        ,
        .stat_txn   (stat_txn),
        .stat_err   (stat_err)
`endif
    );

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Present one request, capture req_ready in the grant cycle, then drop it.
    task automatic issue(input int idx, input logic a, input logic b, output logic [3:0] rdy);
        req_valid = 4'(1 << idx);
        req_a     = a ? req_valid : 4'b0000;
        req_b     = b ? req_valid : 4'b0000;
        @(negedge wb_clk_i);
        rdy = req_ready;
        tick();
        req_valid = '0;
    endtask

    // Bounded wait for the response pulse; returns at the negedge of the RESP cycle.
    task automatic wait_rsp(output logic got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge wb_clk_i);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ce_c      = 1'b0;
        req_valid = '0;
        wb_rst_i  = 1'b1;
        repeat (3) tick();
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if ({busy, ce_a, ce_b, rsp_valid, rsp_c, rsp_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=000000", {busy, ce_a, ce_b, rsp_valid, rsp_c, rsp_err});
        end
        checks++;
        if ({req_ready, rsp_id, rsp_cycles} !== 14'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0", {req_ready, rsp_id, rsp_cycles});
        end
        tick();
    endtask

    task automatic test_follow();
        logic [3:0] rdy;
        logic       got;
        issue(0, 1'b1, 1'b1, rdy);
        checks++;
        if (rdy !== 4'b0001) begin
            errors++;
            $display("FAIL follow_ready got=%b exp=0001", rdy);
        end
        tick();
        checks++;
        if ({busy, ce_a, ce_b} !== 3'b111) begin
            errors++;
            $display("FAIL follow_drive got=%b exp=111", {busy, ce_a, ce_b});
        end
        repeat (3) tick();
        ce_c = 1'b1;
        wait_rsp(got);
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL follow_rsp_timeout got=%b exp=1", got);
        end
        checks++;
        if ({rsp_id, rsp_c, rsp_err, rsp_cycles} !== {2'd0, 1'b1, 1'b0, 8'd5}) begin
            errors++;
            $display("FAIL follow_rsp id/c/err/cyc got=%0d/%0b/%0b/%0d exp=0/1/0/5", rsp_id, rsp_c, rsp_err, rsp_cycles);
        end
        tick();
        @(negedge wb_clk_i);
        checks++;
        if ({rsp_valid, busy, rsp_cycles} !== {1'b0, 1'b0, 8'd5}) begin
            errors++;
            $display("FAIL follow_after valid/busy/cyc got=%0b/%0b/%0d exp=0/0/5", rsp_valid, busy, rsp_cycles);
        end
        tick();
    endtask

    task automatic test_hold();
        logic [3:0] rdy;
        logic       got;
        issue(1, 1'b1, 1'b0, rdy);
        checks++;
        if (rdy !== 4'b0010) begin
            errors++;
            $display("FAIL hold_ready got=%b exp=0010", rdy);
        end
        wait_rsp(got);
        checks++;
        if ({got, ce_a, ce_b, rsp_id, rsp_c, rsp_err, rsp_cycles} !== {1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 8'd3}) begin
            errors++;
            $display("FAIL hold_ok got/ce_a/ce_b/id/c/err/cyc=%0b/%0b/%0b/%0d/%0b/%0b/%0d exp=1/1/0/1/1/0/3",
                     got, ce_a, ce_b, rsp_id, rsp_c, rsp_err, rsp_cycles);
        end
        tick();
        issue(1, 1'b1, 1'b0, rdy);
        tick();
        tick();
        ce_c = 1'b0;
        wait_rsp(got);
        checks++;
        if ({got, rsp_id, rsp_c, rsp_err, rsp_cycles} !== {1'b1, 2'd1, 1'b0, 1'b1, 8'd3}) begin
            errors++;
            $display("FAIL hold_glitch got/id/c/err/cyc=%0b/%0d/%0b/%0b/%0d exp=1/1/0/1/3",
                     got, rsp_id, rsp_c, rsp_err, rsp_cycles);
        end
        tick();
    endtask

    task automatic test_timeout();
        logic [3:0] rdy;
        logic       got;
        ce_c = 1'b1;
        repeat (4) tick();
        issue(2, 1'b0, 1'b0, rdy);
        checks++;
        if (rdy !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_ready got=%b exp=0100", rdy);
        end
        wait_rsp(got);
        checks++;
        if ({got, ce_a, ce_b, rsp_id, rsp_c, rsp_err, rsp_cycles} !== {1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'd15}) begin
            errors++;
            $display("FAIL timeout_rsp got/ce_a/ce_b/id/c/err/cyc=%0b/%0b/%0b/%0d/%0b/%0b/%0d exp=1/0/0/2/1/1/15",
                     got, ce_a, ce_b, rsp_id, rsp_c, rsp_err, rsp_cycles);
        end
        tick();
`ifdef MULLER_C_SCHED_STATS_EN
        checks++;
        if ({stat_txn, stat_err} !== {16'd4, 16'd2}) begin
            errors++;
            $display("FAIL stats_count txn/err got=%0d/%0d exp=4/2", stat_txn, stat_err);
        end
`endif
    endtask

    task automatic test_boundary();
        logic [3:0] rdy;
        logic       got;
        issue(3, 1'b0, 1'b0, rdy);
        tick();
        repeat (13) tick();
        ce_c = 1'b0;
        wait_rsp(got);
        checks++;
        if ({got, rsp_id, rsp_c, rsp_err, rsp_cycles} !== {1'b1, 2'd3, 1'b0, 1'b0, 8'd15}) begin
            errors++;
            $display("FAIL boundary_last got/id/c/err/cyc=%0b/%0d/%0b/%0b/%0d exp=1/3/0/0/15",
                     got, rsp_id, rsp_c, rsp_err, rsp_cycles);
        end
        tick();
        issue(0, 1'b0, 1'b0, rdy);
        wait_rsp(got);
        checks++;
        if ({got, rdy, rsp_id, rsp_c, rsp_err, rsp_cycles} !== {1'b1, 4'b0001, 2'd0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL boundary_immediate got/rdy/id/c/err/cyc=%0b/%b/%0d/%0b/%0b/%0d exp=1/0001/0/0/0/0",
                     got, rdy, rsp_id, rsp_c, rsp_err, rsp_cycles);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] grants [5];
        logic [3:0] exp_g;
        logic       got;
        int         n;
        ce_c     = 1'b0;
        wb_rst_i = 1'b1;
        tick();
        @(negedge wb_clk_i);
`ifdef MULLER_C_SCHED_STATS_EN
        checks++;
        if ({stat_txn, stat_err} !== 32'h0) begin
            errors++;
            $display("FAIL stats_reset txn/err got=%0d/%0d exp=0/0", stat_txn, stat_err);
        end
`endif
        tick();
        wb_rst_i  = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_valid = 4'b1111;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge wb_clk_i);
            if (req_ready != 4'b0000) begin
                grants[n] = req_ready;
                n++;
            end
            tick();
        end
        req_valid = '0;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rr_grant_count got=%0d exp=5", n);
        end
        for (int i = 0; i < n; i++) begin
            exp_g = 4'(1 << (i % 4));
            checks++;
            if (grants[i] !== exp_g) begin
                errors++;
                $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grants[i], exp_g);
            end
        end
        wait_rsp(got);
        tick();
        wb_rst_i  = 1'b1;
        req_valid = 4'b0110;
        tick();
        @(negedge wb_clk_i);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rr_ready_in_reset got=%b exp=0000", req_ready);
        end
        tick();
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rr_first_after_reset got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = '0;
        wait_rsp(got);
        checks++;
        if ({got, rsp_id} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL rr_rsp_id got/id=%0b/%0d exp=1/1", got, rsp_id);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        logic [3:0] rdy;
        logic       got;
        int         seen;
        issue(2, 1'b1, 1'b1, rdy);
        tick();
        tick();
        @(negedge wb_clk_i);
        checks++;
        if ({rdy, busy, ce_a, ce_b} !== {4'b0100, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL abort_wait rdy/busy/ce_a/ce_b=%b/%0b/%0b/%0b exp=0100/1/1/1", rdy, busy, ce_a, ce_b);
        end
        tick();
        wb_rst_i = 1'b1;
        ce_c     = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if ({busy, ce_a, ce_b, rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_state busy/ce_a/ce_b/rsp_valid=%b exp=0000", {busy, ce_a, ce_b, rsp_valid});
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge wb_clk_i);
            if (rsp_valid === 1'b1) begin
                seen++;
            end
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_rsp got=%0d exp=0", seen);
        end
        tick();
        issue(1, 1'b1, 1'b1, rdy);
        wait_rsp(got);
        checks++;
        if ({got, rdy, rsp_id, rsp_c, rsp_err, rsp_cycles} !== {1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL abort_recover got/rdy/id/c/err/cyc=%0b/%b/%0d/%0b/%0b/%0d exp=1/0010/1/1/0/0",
                     got, rdy, rsp_id, rsp_c, rsp_err, rsp_cycles);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_follow();
        test_hold();
        test_timeout();
        test_boundary();
        test_round_robin();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
